// File: rtl/star_pkg.sv
// Shared definitions for the STAR softmax front end.
//   DEF_VEC_LEN   : default elements per vector (row)
//   DEF_LUT_LEN   : default width of the CAMSUB one-hot match vector
//   DEF_MV_OFFSET : default offset mapping signed xi to a one-hot position
//   star_seq_state_t : state encoding of the CAMSUB initiator FSM
package star_pkg;

    localparam int DEF_VEC_LEN   = 16;
    localparam int DEF_LUT_LEN   = 64;
    localparam int DEF_MV_OFFSET = 20;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_FIND  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } star_seq_state_t;

endpackage

// File: rtl/star_row_buf.sv
// Row buffer: VEC_LEN x 8-bit register file plus a running signed maximum.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero all entries and the maximum
//   wr_en, wr_idx, wr_data : element write; writing index 0 restarts the max
//   rd_idx, rd_data        : combinational element read
//   row_max  : signed maximum of the elements written since index 0
module star_row_buf
    import star_pkg::*;
#(
    parameter int  VEC_LEN = DEF_VEC_LEN,
    localparam int IDX_W   = $clog2(VEC_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic signed [7:0]       wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [7:0]       rd_data,
    output logic signed [7:0]       row_max
);

    logic signed [7:0] mem [VEC_LEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VEC_LEN; i++) mem[i] <= '0;
            row_max <= '0;
        end else if (clear) begin
            for (int i = 0; i < VEC_LEN; i++) mem[i] <= '0;
            row_max <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
            // Element 0 seeds the max so a row never inherits the previous row's max.
            if (wr_idx == '0 || wr_data > row_max) row_max <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/star_camsub_seq.sv
// CAMSUB initiator for the STAR softmax front end. Fetches NUM_VEC rows of
// VEC_LEN signed bytes from data memory, streams each element to the CAMSUB
// responder, then issues FindSub readouts and forwards the returned xi-max
// values. Both responder results are checked against a local reference and
// mismatches are counted in saturating counters.
//
// Strobe protocol (no back-pressure): every *_req is a single-cycle request
// that is always accepted; its response is valid exactly one cycle later
// (data after data_req, i_xi_MV after CAMSUB_req, sub_xi after FindSub_req).
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : run request, sampled only in IDLE
//   data_req, data_addr   : memory read request / address
//   data                  : memory read data
//   CAMSUB_req, xi        : element insert strobe / value
//   i_xi_MV               : responder one-hot match vector
//   FindSub_req, sub_xi   : subtraction readout strobe / responder result
//   sub_valid, sub_data, sub_idx : registered result stream
//   busy, done            : activity flag, end-of-run pulse
//   mv_err_cnt, sub_err_cnt : saturating mismatch counters
//   state                 : current FSM state (debug visibility)
module star_camsub_seq
    import star_pkg::*;
#(
    parameter int  VEC_LEN   = DEF_VEC_LEN,
    parameter int  NUM_VEC   = 16,
    parameter int  ADDR_W    = 9,
    parameter int  LUT_LEN   = DEF_LUT_LEN,
    parameter int  MV_OFFSET = DEF_MV_OFFSET,
    localparam int IDX_W     = $clog2(VEC_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                data_req,
    output logic [ADDR_W-1:0]   data_addr,
    input  logic [7:0]          data,
    output logic                CAMSUB_req,
    output logic signed [7:0]   xi,
    input  logic [LUT_LEN-1:0]  i_xi_MV,
    output logic                FindSub_req,
    input  logic signed [7:0]   sub_xi,
    output logic                sub_valid,
    output logic [7:0]          sub_data,
    output logic [IDX_W-1:0]    sub_idx,
    output logic                busy,
    output logic                done,
    output logic [15:0]         mv_err_cnt,
    output logic [15:0]         sub_err_cnt,
    output star_seq_state_t     state
);

    localparam int ROW_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int K_W   = IDX_W + 1;   // k runs 0..VEC_LEN+1
    localparam logic [K_W-1:0]   K_LAST     = K_W'(VEC_LEN + 1);
    localparam logic [K_W-1:0]   K_REQ_LAST = K_W'(VEC_LEN - 1);
    localparam logic [IDX_W-1:0] J_LAST     = IDX_W'(VEC_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(NUM_VEC - 1);

    logic [ROW_W-1:0]  row;
    logic [K_W-1:0]    k;
    logic [IDX_W-1:0]  j;
    logic              rd_pend;     // data is valid this cycle
    logic [IDX_W-1:0]  rd_idx;
    logic              chk_pend;    // i_xi_MV is valid this cycle
    logic signed [7:0] chk_xi;
    logic              sub_pend;    // sub_xi is valid this cycle
    logic [IDX_W-1:0]  sub_j;
    logic signed [7:0] buf_rd;
    logic signed [7:0] row_max;
    logic [7:0]        sub_exp;

    // One-hot position of xi; values mapping outside the LUT expect no match.
    function automatic logic [LUT_LEN-1:0] mv_expect(input logic signed [7:0] v);
        int p;
        p = int'(v) + MV_OFFSET;
        for (int i = 0; i < LUT_LEN; i++) mv_expect[i] = (p == i);
    endfunction

    star_row_buf #(.VEC_LEN(VEC_LEN)) u_row_buf (
        .clk     (clk),
        .rst     (reset),
        .clear   (state == S_IDLE && start),
        .wr_en   (rd_pend),
        .wr_idx  (rd_idx),
        .wr_data (data),
        .rd_idx  (sub_j),
        .rd_data (buf_rd),
        .row_max (row_max)
    );

    // Reference result, wrapping in 8 bits like the responder.
    assign sub_exp = 8'(buf_rd - row_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            row         <= '0;
            k           <= '0;
            j           <= '0;
            data_req    <= 1'b0;
            data_addr   <= '0;
            CAMSUB_req  <= 1'b0;
            xi          <= '0;
            FindSub_req <= 1'b0;
            rd_pend     <= 1'b0;
            rd_idx      <= '0;
            chk_pend    <= 1'b0;
            chk_xi      <= '0;
            sub_pend    <= 1'b0;
            sub_j       <= '0;
            sub_valid   <= 1'b0;
            sub_data    <= '0;
            sub_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mv_err_cnt  <= '0;
            sub_err_cnt <= '0;
        end else begin
            // Response pipelines run every cycle; they are idle outside a run.
            rd_pend    <= data_req;
            rd_idx     <= k[IDX_W-1:0];
            CAMSUB_req <= rd_pend;
            if (rd_pend) xi <= data;
            chk_pend   <= CAMSUB_req;
            chk_xi     <= xi;
            if (chk_pend && i_xi_MV != mv_expect(chk_xi) && mv_err_cnt != 16'hFFFF)
                mv_err_cnt <= mv_err_cnt + 16'd1;
            sub_pend   <= FindSub_req;
            sub_j      <= j;
            sub_valid  <= sub_pend;
            if (sub_pend) begin
                sub_data <= sub_xi;
                sub_idx  <= sub_j;
                if (sub_xi != sub_exp && sub_err_cnt != 16'hFFFF)
                    sub_err_cnt <= sub_err_cnt + 16'd1;
            end
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_FETCH;
                        busy        <= 1'b1;
                        row         <= '0;
                        k           <= '0;
                        data_req    <= 1'b1;
                        data_addr   <= '0;
                        mv_err_cnt  <= '0;
                        sub_err_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    k        <= k + K_W'(1);
                    data_req <= (k < K_REQ_LAST);
                    if (k < K_REQ_LAST) data_addr <= data_addr + ADDR_W'(1);
                    if (k == K_LAST) begin
                        state       <= S_FIND;
                        j           <= '0;
                        FindSub_req <= 1'b1;
                    end
                end
                S_FIND: begin
                    j <= j + IDX_W'(1);
                    if (j == J_LAST) begin
                        state       <= S_FLUSH;
                        FindSub_req <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (row != ROW_LAST) begin
                        row       <= row + ROW_W'(1);
                        state     <= S_FETCH;
                        k         <= '0;
                        data_req  <= 1'b1;
                        // Rows are contiguous: next row starts right after the last address.
                        data_addr <= data_addr + ADDR_W'(1);
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_star_camsub_seq.sv
module tb_star_camsub_seq;
  import star_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start;
  logic              data_req;
  logic [8:0]        data_addr;
  logic [7:0]        data;
  logic              CAMSUB_req;
  logic signed [7:0] xi;
  logic [63:0]       i_xi_MV;
  logic              FindSub_req;
  logic signed [7:0] sub_xi;
  logic              sub_valid;
  logic [7:0]        sub_data;
  logic [3:0]        sub_idx;
  logic              busy;
  logic              done;
  logic [15:0]       mv_err_cnt;
  logic [15:0]       sub_err_cnt;
  star_seq_state_t   state;

  star_camsub_seq #(
    .VEC_LEN(16), .NUM_VEC(16), .ADDR_W(9), .LUT_LEN(64), .MV_OFFSET(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .data_req(data_req), .data_addr(data_addr), .data(data),
    .CAMSUB_req(CAMSUB_req), .xi(xi), .i_xi_MV(i_xi_MV),
    .FindSub_req(FindSub_req), .sub_xi(sub_xi),
    .sub_valid(sub_valid), .sub_data(sub_data), .sub_idx(sub_idx),
    .busy(busy), .done(done),
    .mv_err_cnt(mv_err_cnt), .sub_err_cnt(sub_err_cnt), .state(state)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int mode     = 0;   // 0 clean responder, 1 corrupting, 2 non-zero for xi=44

  logic [7:0]        mem [256];
  logic [11:0]       exp_q [$];   // {sub_idx, sub_data}
  logic signed [7:0] rbuf [16];
  logic [7:0]        cap_xi [256];
  logic [7:0]        cap_sub [256];
  int                addr_hits [256];

  logic        rd_pend_m, mv_pend_m, sb_pend_m;
  logic [7:0]  rd_addr_m;
  logic [63:0] mv_val_m;
  logic [7:0]  sb_val_m;
  int resp_e, resp_f;
  int first_req, first_cam, first_find, first_sv, last_sv, done_cyc, sv_count, overlap_cnt;

  typedef struct {
    int         pos;
    logic [7:0] x;
    logic [7:0] sub;
  } vec_t;
  vec_t tbl [24];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] resp_mv(input logic signed [7:0] x, input int e);
    logic [63:0] v;
    int p;
    p = int'(x) + 20;
    v = '0;
    for (int i = 0; i < 64; i++) if (p == i) v[i] = 1'b1;
    if (mode == 1 && (e == 2 || e == 5 || e == 9)) v = v ^ 64'h8000_0000_0000_0000;
    if (mode == 2 && x == 8'sd44) v = 64'h1;
    return v;
  endfunction

  task automatic clear_stats();
    first_req = -1; first_cam = -1; first_find = -1; first_sv = -1;
    last_sv = -1; done_cyc = -1; sv_count = 0; overlap_cnt = 0;
    resp_e = 0; resp_f = 0;
    for (int i = 0; i < 256; i++) addr_hits[i] = 0;
    exp_q.delete();
  endtask

  // ---------------- driver / responder / monitor, one cycle ----------------
  task automatic tick();
    int rel;
    int mx;
    @(negedge clk);
    cyc++;
    data    = rd_pend_m ? mem[rd_addr_m] : 8'h00;
    i_xi_MV = mv_pend_m ? mv_val_m : 64'h0;
    sub_xi  = sb_pend_m ? sb_val_m : 8'sh00;
    if (reset) begin
      rd_pend_m = 1'b0; mv_pend_m = 1'b0; sb_pend_m = 1'b0;
      return;
    end
    rel = cyc - t0;
    rd_pend_m = data_req;
    rd_addr_m = data_addr[7:0];
    mv_pend_m = CAMSUB_req;
    if (CAMSUB_req) begin
      mv_val_m = resp_mv(xi, resp_e);
      rbuf[resp_e % 16] = xi;
      if (resp_e < 256) cap_xi[resp_e] = xi;
      if (first_cam < 0) first_cam = rel;
      resp_e++;
    end
    sb_pend_m = FindSub_req;
    if (FindSub_req) begin
      mx = rbuf[0];
      for (int i = 1; i < 16; i++) if (int'(rbuf[i]) > mx) mx = rbuf[i];
      sb_val_m = 8'(int'(rbuf[resp_f % 16]) - mx);
      if (mode == 1 && (resp_f == 17 || resp_f == 200)) sb_val_m = sb_val_m ^ 8'h01;
      if (first_find < 0) first_find = rel;
      resp_f++;
    end
    if (data_req) begin
      if (first_req < 0) first_req = rel;
      addr_hits[data_addr[7:0]]++;
    end
    if (FindSub_req && (data_req || CAMSUB_req)) overlap_cnt++;
    if (sub_valid) begin
      if (exp_q.size() == 0) begin
        check("sub_stream_extra", 1, 0);
      end else begin
        check("sub_stream", int'({sub_idx, sub_data}), int'(exp_q.pop_front()));
      end
      if (first_sv < 0) first_sv = rel;
      last_sv = rel;
      if (sv_count < 256) cap_sub[sv_count] = sub_data;
      sv_count++;
    end
    if (done && done_cyc < 0) done_cyc = rel;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data_req"},    int'(data_req),    0);
    check({tag, "_camsub_req"},  int'(CAMSUB_req),  0);
    check({tag, "_findsub_req"}, int'(FindSub_req), 0);
    check({tag, "_busy"},        int'(busy),        0);
    check({tag, "_done"},        int'(done),        0);
    check({tag, "_sub_valid"},   int'(sub_valid),   0);
    check({tag, "_data_addr"},   int'(data_addr),   0);
    check({tag, "_xi"},          int'(xi),          0);
    check({tag, "_sub_data"},    int'(sub_data),    0);
    check({tag, "_sub_idx"},     int'(sub_idx),     0);
    check({tag, "_mv_err"},      int'(mv_err_cnt),  0);
    check({tag, "_sub_err"},     int'(sub_err_cnt), 0);
    check({tag, "_state"},       int'(state),       int'(S_IDLE));
  endtask

  task automatic build_expected();
    int mx, v;
    for (int r = 0; r < 16; r++) begin
      mx = -1000;
      for (int i = 0; i < 16; i++) begin
        v = int'($signed(mem[r*16+i]));
        if (v > mx) mx = v;
      end
      for (int i = 0; i < 16; i++) begin
        logic [7:0] d;
        d = 8'(int'($signed(mem[r*16+i])) - mx);
        if (mode == 1 && (r*16+i == 17 || r*16+i == 200)) d = d ^ 8'h01;
        exp_q.push_back({4'(i), d});
      end
    end
  endtask

  task automatic do_run(input string tag, input int m, input int exp_mv, input int exp_sub,
                        input bit poke_start);
    int bad_addr;
    mode = m;
    clear_stats();
    build_expected();
    tick();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int n = 0; n < 700 && done_cyc < 0; n++) begin
      tick();
      start = (poke_start && (cyc - t0) == 100);
    end
    start = 1'b0;
    if (done_cyc < 0) check({tag, "_done_timeout"}, 0, 1);
    tick();
    check({tag, "_done_cycle"},   done_cyc,    561);
    check({tag, "_first_req"},    first_req,   1);
    check({tag, "_first_camsub"}, first_cam,   3);
    check({tag, "_first_find"},   first_find,  19);
    check({tag, "_first_sv"},     first_sv,    21);
    check({tag, "_last_sv"},      last_sv,     561);
    check({tag, "_sv_count"},     sv_count,    256);
    check({tag, "_overlap"},      overlap_cnt, 0);
    check({tag, "_exp_left"},     exp_q.size(), 0);
    bad_addr = 0;
    for (int i = 0; i < 256; i++) if (addr_hits[i] != 1) bad_addr++;
    check({tag, "_addr_sweep"},   bad_addr,    0);
    check({tag, "_mv_err"},       int'(mv_err_cnt),  exp_mv);
    check({tag, "_sub_err"},      int'(sub_err_cnt), exp_sub);
    check({tag, "_idle_busy"},    int'(busy),  0);
    check({tag, "_idle_state"},   int'(state), int'(S_IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; data = '0; i_xi_MV = '0; sub_xi = '0;
    rd_pend_m = 1'b0; mv_pend_m = 1'b0; sb_pend_m = 1'b0;
    rd_addr_m = '0; mv_val_m = '0; sb_val_m = '0;
    for (int i = 0; i < 16; i++) rbuf[i] = '0;
    clear_stats();

    // Memory image: row0 zeros, row1 -5..10, row2 range corners, row3 wrap, rest mixed.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[16+i] = 8'(i - 5);
    mem[32] = 8'hEB;  // -21
    mem[33] = 8'h2C;  // 44
    for (int i = 0; i < 14; i++) mem[34+i] = 8'(i);
    mem[48] = 8'h80;
    mem[49] = 8'h7F;
    for (int r = 4; r < 16; r++)
      for (int i = 0; i < 16; i++) begin
        mem[r*16+i] = 8'((r*29 + i*13) ^ (i << 4));
        if (mem[r*16+i] == 8'h2C) mem[r*16+i] = 8'h2D;
      end

    // Hand-computed element table: {global position, xi, xi - row max}.
    tbl[0] = '{0,  8'h00, 8'h00};
    tbl[1] = '{15, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) tbl[2+i] = '{16+i, 8'(i - 5), 8'(i - 15)};
    tbl[18] = '{32, 8'hEB, 8'hBF};
    tbl[19] = '{33, 8'h2C, 8'h00};
    tbl[20] = '{34, 8'h00, 8'hD4};
    tbl[21] = '{47, 8'h0D, 8'hE1};
    tbl[22] = '{48, 8'h80, 8'h01};
    tbl[23] = '{50, 8'h00, 8'h81};

    repeat (3) tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    // Clean responder: table values and stream.
    do_run("clean", 0, 0, 0, 1'b0);
    for (int t = 0; t < 24; t++) begin
      check($sformatf("tbl_xi_%0d", tbl[t].pos),  int'(cap_xi[tbl[t].pos]),  int'(tbl[t].x));
      check($sformatf("tbl_sub_%0d", tbl[t].pos), int'(cap_sub[tbl[t].pos]), int'(tbl[t].sub));
    end

    // Corrupting responder, plus a start pulse while busy.
    do_run("corrupt", 1, 3, 2, 1'b1);

    // Responder answers xi=44 with a non-zero vector.
    do_run("mv44", 2, 1, 0, 1'b0);

    // Reset in the middle of a run.
    mode = 1;
    clear_stats();
    tick();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40 && (cyc - t0) < 20; n++) tick();
    check("midrun_busy",   int'(busy),       1);
    check("midrun_mv_err", int'(mv_err_cnt), 3);
    reset = 1'b1;
    #1;
    check_reset_vals("midrun_rst");
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_run("after_rst", 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
